// File: rtl/calc_sequencer_pkg.sv
// Shared types and default sizing for the calculator control path.
// The state and operator encodings are visible to the datapath and the bench.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ENTER_OP = 3'd2,
        ISSUE    = 3'd3,
        WAIT     = 3'd4,
        SHOW     = 3'd5,
        ABORT    = 3'd6
    } calc_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    localparam int CALC_WIDTH    = 8;
    localparam int CALC_TIMEOUT  = 1024;
    localparam int CALC_DEBOUNCE = 16;

endpackage

// File: rtl/calc_sequencer_if.sv
// Start/done handshake and operand bus between the sequencer and the ALU.
// The sequencer is the master; the ALU answers with a done pulse plus result/error.
interface calc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                 alu_start;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [1:0]           op;
    logic                 alu_done;
    logic [2*WIDTH-1:0]   alu_result;
    logic                 alu_err;

    modport master (
        output alu_start, opa, opb, op,
        input  alu_done, alu_result, alu_err
    );

    modport slave (
        input  alu_start, opa, opb, op,
        output alu_done, alu_result, alu_err
    );
endinterface

// File: rtl/button_release_detect.sv
// Single-cycle pulse on button release; optional debounce under CALC_SEQ_DEBOUNCE_EN.
// Latency: rel is combinational off the filtered level (debounce adds DEBOUNCE_CYCLES+1).
// No backpressure: the pulse is produced once per release and is not held.
module button_release_detect #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rel
);

    logic level;
    logic prev_q;

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          raw_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // The filtered level only follows the registered input once it has
    // disagreed for a full DEBOUNCE_CYCLES run; any agreement restarts the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_q   <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            raw_q <= btn;
            if (raw_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= raw_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
`else
    logic [31:0] unused_debounce_cycles;
    assign unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign level = btn;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rel = prev_q & ~level;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand/operator entry, ALU start/done handshake, result hold.
// Latency: rel in ENTER_OP -> alu_start next cycle; alu_done -> result_valid next cycle.
// Waits on alu_done up to TIMEOUT_CYCLES; clear mid-flight drains the ALU via ABORT.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = CALC_WIDTH,
    parameter int TIMEOUT_CYCLES  = CALC_TIMEOUT,
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 progress,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     sw_data,
    input  logic [1:0]           sw_op,
    calc_sequencer_if.master     alu,
    output logic                 en_a,
    output logic                 en_b,
    output logic                 en_op,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 error,
    output logic                 busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    calc_state_t        state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opb_q;
    calc_op_t           op_q;
    logic [2*WIDTH-1:0] result_q;
    logic               result_valid_q, error_q;
    logic [CNT_W-1:0]   cnt_q;

    logic rel;
    logic timeout;
    logic load_a, load_b, load_op;
    logic cnt_clr, cnt_inc;
    logic cap_done, cap_timeout, clr_status;

    button_release_detect #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rel (
        .clk   (clk),
        .reset (reset),
        .btn   (progress),
        .rel   (rel)
    );

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        clr_status  = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (clear) begin
                    state_d = ENTER_A;
                end else if (rel) begin
                    load_a     = 1'b1;
                    clr_status = 1'b1;
                    state_d    = ENTER_B;
                end
            end
            ENTER_B: begin
                if (clear) begin
                    state_d = ENTER_A;
                end else if (rel) begin
                    load_b  = 1'b1;
                    state_d = ENTER_OP;
                end
            end
            ENTER_OP: begin
                if (clear) begin
                    state_d = ENTER_A;
                end else if (rel) begin
                    load_op = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The start pulse is already out, so a clear here must still drain.
                cnt_clr = 1'b1;
                state_d = clear ? ABORT : WAIT;
            end
            WAIT: begin
                cnt_inc = 1'b1;
                if (clear) begin
                    state_d = ABORT;
                end else if (alu.alu_done) begin
                    cap_done = 1'b1;
                    state_d  = SHOW;
                end else if (timeout) begin
                    cap_timeout = 1'b1;
                    state_d     = SHOW;
                end
            end
            SHOW: begin
                if (clear) begin
                    clr_status = 1'b1;
                    state_d    = ENTER_A;
                end else if (rel) begin
                    state_d = ENTER_A;
                end
            end
            ABORT: begin
                cnt_inc = 1'b1;
                if (alu.alu_done || timeout) begin
                    state_d = ENTER_A;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q          <= '0;
            opb_q          <= '0;
            op_q           <= OP_ADD;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            cnt_q          <= '0;
        end else begin
            if (load_a) opa_q <= sw_data;
            if (load_b) opb_q <= sw_data;
            if (load_op) op_q <= calc_op_t'(sw_op);

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (cap_done) begin
                result_q       <= alu.alu_result;
                error_q        <= alu.alu_err;
                result_valid_q <= ~alu.alu_err;
            end else if (cap_timeout) begin
                error_q        <= 1'b1;
                result_valid_q <= 1'b0;
            end else if (clr_status) begin
                error_q        <= 1'b0;
                result_valid_q <= 1'b0;
            end
        end
    end

    assign en_a          = (state_q == ENTER_A);
    assign en_b          = (state_q == ENTER_B);
    assign en_op         = (state_q == ENTER_OP);
    assign busy          = (state_q == ISSUE) || (state_q == WAIT) || (state_q == ABORT);
    assign alu.alu_start = (state_q == ISSUE);
    assign alu.opa       = opa_q;
    assign alu.opb       = opb_q;
    assign alu.op        = op_q;
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign error         = error_q;

endmodule
